core_bus_arbiter: RTL and testbench

// Shares one pipelined Avalon-MM memory port between the core's instruction bus (read-only) and data bus.
// Per-command round-robin arbitration; grant held while the granted command is stalled.

---
 rtl/core_bus_arbiter.sv | 111 +++++++++++
 tb/tb_core_bus_arbiter.sv | 486 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_bus_arbiter.sv
// Two-master Avalon-MM arbiter: per-command round-robin between ibus and dbus, grant held
// across slave stalls, and read responses steered back in issue order by an owner FIFO.
module core_bus_arbiter #(
    parameter int unsigned AW              = 32,
    parameter int unsigned DW              = 32,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            ibus_read_i,
    input  logic [AW-1:0]   ibus_address_i,
    output logic            ibus_waitrequest_o,
    output logic [DW-1:0]   ibus_readdata_o,
    output logic            ibus_readdatavalid_o,
    input  logic            dbus_read_i,
    input  logic            dbus_write_i,
    input  logic [AW-1:0]   dbus_address_i,
    input  logic [DW-1:0]   dbus_writedata_i,
    input  logic [DW/8-1:0] dbus_byteenable_i,
    output logic            dbus_waitrequest_o,
    output logic [DW-1:0]   dbus_readdata_o,
    output logic            dbus_readdatavalid_o,
    output logic            mem_read_o,
    output logic            mem_write_o,
    output logic [AW-1:0]   mem_address_o,
    output logic [DW-1:0]   mem_writedata_o,
    output logic [DW/8-1:0] mem_byteenable_o,
    input  logic            mem_waitrequest_i,
    input  logic [DW-1:0]   mem_readdata_i,
    input  logic            mem_readdatavalid_i
);
    localparam int unsigned PW        = $clog2(MAX_OUTSTANDING);
    localparam logic [PW:0] FullCount = MAX_OUTSTANDING[PW:0];

    logic                       last_grant_q;
    logic                       lock_q;
    logic                       lock_sel_q;
    logic [MAX_OUTSTANDING-1:0] owner_q;
    logic [PW-1:0]              wptr_q;
    logic [PW-1:0]              rptr_q;
    logic [PW:0]                count_q;

    logic full, ibus_elig, dbus_elig;
    logic sel, gnt_valid, accept, push, pop;

    always_comb begin
        full      = (count_q == FullCount);
        ibus_elig = ibus_read_i & ~full;
        dbus_elig = dbus_write_i | (dbus_read_i & ~full);
        if (lock_q) begin
            sel       = lock_sel_q;
            gnt_valid = lock_sel_q ? dbus_elig : ibus_elig;
        end else begin
            gnt_valid = ibus_elig | dbus_elig;
            sel       = (ibus_elig & dbus_elig) ? ~last_grant_q : dbus_elig;
        end
    end

    always_comb begin
        mem_read_o         = gnt_valid & (sel ? dbus_read_i : ibus_read_i);
        mem_write_o        = gnt_valid & sel & dbus_write_i;
        mem_address_o      = sel ? dbus_address_i : ibus_address_i;
        mem_writedata_o    = sel ? dbus_writedata_i : '0;
        mem_byteenable_o   = sel ? dbus_byteenable_i : '1;
        ibus_waitrequest_o = ~(gnt_valid & ~sel) | mem_waitrequest_i;
        dbus_waitrequest_o = ~(gnt_valid & sel) | mem_waitrequest_i;
    end

    assign accept = gnt_valid & ~mem_waitrequest_i;
    assign push   = accept & mem_read_o;
    // Responses arriving with nothing outstanding (e.g. from before a reset) are discarded.
    assign pop    = mem_readdatavalid_i & (count_q != '0);

    assign ibus_readdata_o      = mem_readdata_i;
    assign dbus_readdata_o      = mem_readdata_i;
    assign ibus_readdatavalid_o = pop & ~owner_q[rptr_q];
    assign dbus_readdatavalid_o = pop & owner_q[rptr_q];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_grant_q <= 1'b0;
            lock_q       <= 1'b0;
            lock_sel_q   <= 1'b0;
            owner_q      <= '0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
        end else begin
            // A stalled command keeps the grant so its fields stay stable until accepted.
            lock_q <= gnt_valid & mem_waitrequest_i;
            if (gnt_valid) begin
                lock_sel_q <= sel;
            end
            if (accept) begin
                last_grant_q <= sel;
            end
            if (push) begin
                owner_q[wptr_q] <= sel;
                wptr_q          <= wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + {{PW{1'b0}}, 1'b1};
                2'b01:   count_q <= count_q - {{PW{1'b0}}, 1'b1};
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: tb/tb_core_bus_arbiter.sv
// Self-checking bench for core_bus_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based reference model of the arbitration and response routing.
module tb_core_bus_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          ibus_read;
    logic [AW-1:0] ibus_address;
    logic          ibus_waitrequest;
    logic [DW-1:0] ibus_readdata;
    logic          ibus_readdatavalid;
    logic          dbus_read;
    logic          dbus_write;
    logic [AW-1:0] dbus_address;
    logic [DW-1:0] dbus_writedata;
    logic [3:0]    dbus_byteenable;
    logic          dbus_waitrequest;
    logic [DW-1:0] dbus_readdata;
    logic          dbus_readdatavalid;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_writedata;
    logic [3:0]    mem_byteenable;
    logic          mem_waitrequest;
    logic [DW-1:0] mem_readdata;
    logic          mem_readdatavalid;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: last winner, held grant, and the owners of outstanding reads in order.
    bit m_last;
    bit m_lock;
    bit m_lock_sel;
    bit owners[$];

    always #5 clk = ~clk;

    core_bus_arbiter #(
        .AW(AW),
        .DW(DW),
        .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk_i                (clk),
        .rst_i                (rst),
        .ibus_read_i          (ibus_read),
        .ibus_address_i       (ibus_address),
        .ibus_waitrequest_o   (ibus_waitrequest),
        .ibus_readdata_o      (ibus_readdata),
        .ibus_readdatavalid_o (ibus_readdatavalid),
        .dbus_read_i          (dbus_read),
        .dbus_write_i         (dbus_write),
        .dbus_address_i       (dbus_address),
        .dbus_writedata_i     (dbus_writedata),
        .dbus_byteenable_i    (dbus_byteenable),
        .dbus_waitrequest_o   (dbus_waitrequest),
        .dbus_readdata_o      (dbus_readdata),
        .dbus_readdatavalid_o (dbus_readdatavalid),
        .mem_read_o           (mem_read),
        .mem_write_o          (mem_write),
        .mem_address_o        (mem_address),
        .mem_writedata_o      (mem_writedata),
        .mem_byteenable_o     (mem_byteenable),
        .mem_waitrequest_i    (mem_waitrequest),
        .mem_readdata_i       (mem_readdata),
        .mem_readdatavalid_i  (mem_readdatavalid)
    );

    task automatic idle_inputs();
        ibus_read = 0; ibus_address = '0;
        dbus_read = 0; dbus_write = 0; dbus_address = '0; dbus_writedata = '0;
        dbus_byteenable = '0;
        mem_waitrequest = 0; mem_readdata = '0; mem_readdatavalid = 0;
    endtask

    function automatic void model_grant(output bit gv, output bit sel);
        bit full, ie, de;
        full = owners.size() >= MAXO;
        ie   = ibus_read && !full;
        de   = dbus_write || (dbus_read && !full);
        if (m_lock) begin
            sel = m_lock_sel;
            gv  = sel ? de : ie;
        end else begin
            gv  = ie || de;
            sel = (ie && de) ? !m_last : de;
        end
    endfunction

    task automatic model_commit();
        bit gv, sel;
        int pre;
        model_grant(gv, sel);
        pre = owners.size();
        if (rst) begin
            m_last = 0; m_lock = 0; m_lock_sel = 0;
            owners.delete();
            return;
        end
        if (mem_readdatavalid && pre > 0) void'(owners.pop_front());
        if (gv && !mem_waitrequest) begin
            if (sel ? dbus_read : ibus_read) owners.push_back(sel);
            m_last = sel;
            m_lock = 0;
        end else if (gv) begin
            m_lock = 1;
            m_lock_sel = sel;
        end else begin
            m_lock = 0;
        end
    endtask

    task automatic advance();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        advance();
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        vectors++;
        if ({mem_read, mem_write, ibus_waitrequest, dbus_waitrequest,
             ibus_readdatavalid, dbus_readdatavalid} !== 6'b001100) begin
            miscompares++;
            $display("FAIL reset_idle: got %b want 001100", {mem_read, mem_write,
                     ibus_waitrequest, dbus_waitrequest, ibus_readdatavalid, dbus_readdatavalid});
        end
        advance();
        mem_readdatavalid = 1; mem_readdata = 32'h1234;
        @(negedge clk);
        vectors++;
        if ({ibus_readdatavalid, dbus_readdatavalid} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_straggler: got %b want 00", {ibus_readdatavalid, dbus_readdatavalid});
        end
        advance();
        idle_inputs();
    endtask

    task automatic test_single_fetch();
        do_reset();
        ibus_read = 1; ibus_address = 32'h100;
        @(negedge clk);
        vectors++;
        if ({mem_read, mem_write, ibus_waitrequest, dbus_waitrequest} !== 4'b1001 ||
            mem_address !== 32'h100 || mem_byteenable !== 4'hF || mem_writedata !== '0) begin
            miscompares++;
            $display("FAIL fetch_cmd: got ctl=%b addr=%h be=%h wd=%h want 1001/100/f/0",
                     {mem_read, mem_write, ibus_waitrequest, dbus_waitrequest},
                     mem_address, mem_byteenable, mem_writedata);
        end
        advance();
        ibus_read = 0;
        advance();
        mem_readdatavalid = 1; mem_readdata = 32'hDEADBEEF;
        @(negedge clk);
        vectors++;
        if ({ibus_readdatavalid, dbus_readdatavalid} !== 2'b10 || ibus_readdata !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL fetch_resp: got rdv=%b data=%h want 10/deadbeef",
                     {ibus_readdatavalid, dbus_readdatavalid}, ibus_readdata);
        end
        advance();
        idle_inputs();
    endtask

    task automatic test_both_same_cycle();
        do_reset();
        ibus_read = 1; ibus_address = 32'h0;
        dbus_read = 1; dbus_address = 32'h8000;
        @(negedge clk);
        vectors++;
        if (mem_address !== 32'h8000 || {ibus_waitrequest, dbus_waitrequest} !== 2'b10) begin
            miscompares++;
            $display("FAIL both_first: got addr=%h wr=%b want 8000/10",
                     mem_address, {ibus_waitrequest, dbus_waitrequest});
        end
        advance();
        dbus_read = 0;
        @(negedge clk);
        vectors++;
        if (mem_read !== 1'b1 || mem_address !== 32'h0 || ibus_waitrequest !== 1'b0) begin
            miscompares++;
            $display("FAIL both_second: got rd=%b addr=%h iwr=%b want 1/0/0",
                     mem_read, mem_address, ibus_waitrequest);
        end
        advance();
        ibus_read = 0;
        mem_readdatavalid = 1; mem_readdata = 32'hAAAA0001;
        @(negedge clk);
        vectors++;
        if ({ibus_readdatavalid, dbus_readdatavalid} !== 2'b01 || dbus_readdata !== 32'hAAAA0001) begin
            miscompares++;
            $display("FAIL both_resp_a: got rdv=%b data=%h want 01/aaaa0001",
                     {ibus_readdatavalid, dbus_readdatavalid}, dbus_readdata);
        end
        advance();
        mem_readdata = 32'hBBBB0002;
        @(negedge clk);
        vectors++;
        if ({ibus_readdatavalid, dbus_readdatavalid} !== 2'b10 || ibus_readdata !== 32'hBBBB0002) begin
            miscompares++;
            $display("FAIL both_resp_b: got rdv=%b data=%h want 10/bbbb0002",
                     {ibus_readdatavalid, dbus_readdatavalid}, ibus_readdata);
        end
        advance();
        idle_inputs();
    endtask

    task automatic test_write_stall();
        do_reset();
        dbus_write = 1; dbus_address = 32'h10; dbus_writedata = 32'h55AA; dbus_byteenable = 4'hF;
        ibus_read = 1; ibus_address = 32'h200;
        for (int c = 0; c < 4; c++) begin
            mem_waitrequest = (c < 3);
            @(negedge clk);
            vectors++;
            if ({mem_write, mem_read, ibus_waitrequest, dbus_waitrequest} !== {3'b101, c < 3} ||
                mem_address !== 32'h10 || mem_writedata !== 32'h55AA) begin
                miscompares++;
                $display("FAIL stall_hold%0d: got ctl=%b addr=%h wd=%h want %b/10/55aa", c,
                         {mem_write, mem_read, ibus_waitrequest, dbus_waitrequest},
                         mem_address, mem_writedata, {3'b101, c < 3});
            end
            advance();
        end
        dbus_write = 0; mem_waitrequest = 0;
        @(negedge clk);
        vectors++;
        if (mem_read !== 1'b1 || mem_address !== 32'h200 || ibus_waitrequest !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_next: got rd=%b addr=%h iwr=%b want 1/200/0",
                     mem_read, mem_address, ibus_waitrequest);
        end
        advance();
        idle_inputs();
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            ibus_read = 1; ibus_address = 32'h400 + i * 4;
            @(negedge clk);
            vectors++;
            if (mem_read !== 1'b1 || ibus_waitrequest !== 1'b0) begin
                miscompares++;
                $display("FAIL full_fill%0d: got rd=%b iwr=%b want 1/0", i, mem_read, ibus_waitrequest);
            end
            advance();
        end
        ibus_read = 0; dbus_read = 1; dbus_address = 32'h40;
        @(negedge clk);
        vectors++;
        if ({mem_read, mem_write, dbus_waitrequest} !== 3'b001) begin
            miscompares++;
            $display("FAIL full_block: got %b want 001", {mem_read, mem_write, dbus_waitrequest});
        end
        advance();
        mem_readdatavalid = 1; mem_readdata = 32'h1111;
        @(negedge clk);
        vectors++;
        if ({mem_read, dbus_waitrequest, ibus_readdatavalid} !== 3'b011) begin
            miscompares++;
            $display("FAIL full_pushpop: got %b want 011",
                     {mem_read, dbus_waitrequest, ibus_readdatavalid});
        end
        advance();
        mem_readdatavalid = 0;
        @(negedge clk);
        vectors++;
        if (mem_read !== 1'b1 || mem_address !== 32'h40 || dbus_waitrequest !== 1'b0) begin
            miscompares++;
            $display("FAIL full_release: got rd=%b addr=%h dwr=%b want 1/40/0",
                     mem_read, mem_address, dbus_waitrequest);
        end
        advance();
        dbus_read = 0; dbus_write = 1; dbus_address = 32'h44;
        dbus_writedata = 32'hCAFE; dbus_byteenable = 4'b0011;
        @(negedge clk);
        vectors++;
        if ({mem_write, mem_read, dbus_waitrequest} !== 3'b100 || mem_address !== 32'h44 ||
            mem_writedata !== 32'hCAFE || mem_byteenable !== 4'b0011) begin
            miscompares++;
            $display("FAIL full_write: got ctl=%b addr=%h wd=%h be=%b want 100/44/cafe/0011",
                     {mem_write, mem_read, dbus_waitrequest}, mem_address, mem_writedata,
                     mem_byteenable);
        end
        advance();
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        ibus_read = 1; ibus_address = 32'h10;
        advance();
        ibus_read = 0; dbus_read = 1; dbus_address = 32'h20;
        advance();
        idle_inputs();
        rst = 1;
        advance();
        rst = 0;
        for (int k = 0; k < 2; k++) begin
            mem_readdatavalid = 1; mem_readdata = 32'h5A5A0000 + k;
            @(negedge clk);
            vectors++;
            if ({ibus_readdatavalid, dbus_readdatavalid} !== 2'b00) begin
                miscompares++;
                $display("FAIL rstmid_drop%0d: got %b want 00", k,
                         {ibus_readdatavalid, dbus_readdatavalid});
            end
            advance();
        end
        mem_readdatavalid = 0; dbus_read = 1; dbus_address = 32'h300;
        @(negedge clk);
        vectors++;
        if (mem_read !== 1'b1 || mem_address !== 32'h300) begin
            miscompares++;
            $display("FAIL rstmid_issue: got rd=%b addr=%h want 1/300", mem_read, mem_address);
        end
        advance();
        dbus_read = 0; mem_readdatavalid = 1; mem_readdata = 32'h77;
        @(negedge clk);
        vectors++;
        if ({ibus_readdatavalid, dbus_readdatavalid} !== 2'b01 || dbus_readdata !== 32'h77) begin
            miscompares++;
            $display("FAIL rstmid_resp: got rdv=%b data=%h want 01/77",
                     {ibus_readdatavalid, dbus_readdatavalid}, dbus_readdata);
        end
        advance();
        idle_inputs();
    endtask

    // Both masters read continuously; winners must alternate and responses follow issue order.
    task automatic test_alternate();
        int ia, da, issued, returned;
        bit exp_sel;
        bit order[$];
        logic [DW-1:0] rd;
        ia = 0; da = 0; issued = 0; returned = 0; exp_sel = 1;
        do_reset();
        for (int cyc = 0; cyc < 60 && returned < 16; cyc++) begin
            ibus_read = (issued < 16); dbus_read = (issued < 16);
            ibus_address = 32'h1000 + ia * 4;
            dbus_address = 32'h2000 + da * 4;
            mem_readdatavalid = (order.size() >= 2) || (issued >= 16 && order.size() > 0);
            rd = $urandom;
            mem_readdata = rd;
            @(negedge clk);
            if (issued < 16) begin
                vectors++;
                if (mem_read !== 1'b1 || {ibus_waitrequest, dbus_waitrequest} !== {exp_sel, !exp_sel} ||
                    mem_address !== (exp_sel ? dbus_address : ibus_address)) begin
                    miscompares++;
                    $display("FAIL alt_grant%0d: got rd=%b wr=%b addr=%h want sel=%0d", issued,
                             mem_read, {ibus_waitrequest, dbus_waitrequest}, mem_address, exp_sel);
                end
            end
            if (mem_readdatavalid) begin
                vectors++;
                if ({ibus_readdatavalid, dbus_readdatavalid} !== {!order[0], order[0]} ||
                    (order[0] ? dbus_readdata : ibus_readdata) !== rd) begin
                    miscompares++;
                    $display("FAIL alt_resp%0d: got rdv=%b want owner %0d data %h", returned,
                             {ibus_readdatavalid, dbus_readdatavalid}, order[0], rd);
                end
            end
            advance();
            if (mem_readdatavalid) begin
                void'(order.pop_front());
                returned++;
            end
            if (issued < 16) begin
                order.push_back(exp_sel);
                if (exp_sel) da++; else ia++;
                issued++;
                exp_sel = !exp_sel;
            end
        end
        vectors++;
        if (returned != 16) begin
            miscompares++;
            $display("FAIL alt_timeout: got %0d responses want 16", returned);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        bit ib_pend, db_pend;
        ib_pend = 0; db_pend = 0;
        do_reset();
        for (int cyc = 0; cyc < 500; cyc++) begin
            bit gv, sel, e_ir, e_dr;
            rst = ($urandom_range(0, 99) == 0);
            if (!ib_pend && $urandom_range(0, 2) != 0) begin
                ib_pend = 1;
                ibus_address = $urandom;
            end
            ibus_read = ib_pend;
            if (!db_pend && $urandom_range(0, 2) != 0) begin
                db_pend = 1;
                dbus_address = $urandom;
                dbus_writedata = $urandom;
                dbus_byteenable = 4'($urandom);
                dbus_write = 1'($urandom_range(0, 1));
                dbus_read = !dbus_write;
            end
            if (!db_pend) begin
                dbus_read = 0; dbus_write = 0;
            end
            mem_waitrequest = ($urandom_range(0, 3) == 0);
            mem_readdatavalid = ($urandom_range(0, 2) == 0);
            mem_readdata = $urandom;
            model_grant(gv, sel);
            e_ir = 0; e_dr = 0;
            if (mem_readdatavalid && owners.size() > 0) begin
                e_ir = !owners[0];
                e_dr = owners[0];
            end
            @(negedge clk);
            vectors++;
            if ({mem_read, mem_write, ibus_waitrequest, dbus_waitrequest,
                 ibus_readdatavalid, dbus_readdatavalid} !==
                {gv && (sel ? dbus_read : ibus_read), gv && sel && dbus_write,
                 !(gv && !sel) || mem_waitrequest, !(gv && sel) || mem_waitrequest, e_ir, e_dr}) begin
                miscompares++;
                $display("FAIL rand_ctl%0d: got %b want gv=%0d sel=%0d rdv=%b%b", cyc,
                         {mem_read, mem_write, ibus_waitrequest, dbus_waitrequest,
                          ibus_readdatavalid, dbus_readdatavalid}, gv, sel, e_ir, e_dr);
            end
            if (gv) begin
                vectors++;
                if (mem_address !== (sel ? dbus_address : ibus_address) ||
                    mem_writedata !== (sel ? dbus_writedata : 32'h0) ||
                    mem_byteenable !== (sel ? dbus_byteenable : 4'hF)) begin
                    miscompares++;
                    $display("FAIL rand_mux%0d: got addr=%h wd=%h be=%h for sel=%0d", cyc,
                             mem_address, mem_writedata, mem_byteenable, sel);
                end
            end
            if (e_ir || e_dr) begin
                vectors++;
                if ((e_dr ? dbus_readdata : ibus_readdata) !== mem_readdata) begin
                    miscompares++;
                    $display("FAIL rand_data%0d: got %h want %h", cyc,
                             e_dr ? dbus_readdata : ibus_readdata, mem_readdata);
                end
            end
            if (gv && !mem_waitrequest) begin
                if (sel) db_pend = 0; else ib_pend = 0;
            end
            advance();
        end
        rst = 0;
        idle_inputs();
    endtask

    initial begin
        rst = 0;
        idle_inputs();
        m_last = 0; m_lock = 0; m_lock_sel = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_single_fetch();
        test_both_same_cycle();
        test_write_stall();
        test_full();
        test_reset_mid();
        test_alternate();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
